// File: rtl/cplx_pkg.sv
// Shared definitions for the complex accumulator: ALU/result widths and FSM state type.
package cplx_pkg;

  // Width of one ALU operand part.
  localparam int ALU_W  = 5;
  // One result part holds a full ALU_W x ALU_W product plus one carry bit.
  localparam int PART_W = 2 * ALU_W + 1;
  // Result bus carries real (upper) and imaginary (lower) parts.
  localparam int RES_W  = 2 * PART_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage : cplx_pkg

// File: rtl/cplx_accumulator_if.sv
// Beat input / sum output bundle for cplx_accumulator.
// master = producer of beats and consumer of sums; slave = the accumulator.
interface cplx_accumulator_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  import cplx_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [RES_W-1:0]   in_result;
  logic               in_ovf_real;
  logic               in_ovf_imag;
  logic               in_last;

  logic               out_valid;
  logic               out_ready;
  logic [2*ACC_W-1:0] out_sum;
  logic [CNT_W-1:0]   out_count;
  logic               out_ovf_real;
  logic               out_ovf_imag;

  modport master (
    output in_valid, in_result, in_ovf_real, in_ovf_imag, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf_real, out_ovf_imag
  );

  modport slave (
    input  in_valid, in_result, in_ovf_real, in_ovf_imag, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf_real, out_ovf_imag
  );

endinterface : cplx_accumulator_if

// File: rtl/cplx_sat_add.sv
// W-bit signed adder with overflow flag.
// With CPLX_ACC_SAT_EN defined the result clamps to the signed range on
// overflow; otherwise it wraps modulo 2^W.
module cplx_sat_add #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  logic signed [W-1:0] raw;

  // Raw add, signed-overflow detect, optional clamp.
  always_comb begin
    // NOTE: every output gets a value before any condition, so no path can leave it unassigned and infer a latch.
    raw = a + b;
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    sum = raw;
`ifdef CPLX_ACC_SAT_EN
    if (ovf) begin
      // Both operands negative -> most negative value, else most positive.
      sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

endmodule : cplx_sat_add

// File: rtl/cplx_accumulator.sv
// Complex (real/imag) beat accumulator with sticky per-half overflow flags.
// Accepts beats until in_last, then holds the sum until the consumer takes it.
// Optional macro CPLX_ACC_SAT_EN: clamp each half on overflow instead of wrapping.
module cplx_accumulator
  import cplx_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  cplx_accumulator_if.slave   bus
);

  state_t state_q, state_d;

  logic                    ready_en_q;
  logic                    accept;
  logic                    out_fire;

  logic signed [ACC_W-1:0] acc_r_q, acc_i_q;
  logic signed [ACC_W-1:0] sext_r, sext_i;
  logic signed [ACC_W-1:0] add_r, add_i;
  logic                    add_ovf_r, add_ovf_i;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ovf_r_q, ovf_i_q;

  // in_ready depends only on registered state, never on in_valid.
  assign bus.in_ready  = ready_en_q && (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign accept        = bus.in_valid && bus.in_ready;
  assign out_fire      = bus.out_valid && bus.out_ready;

  assign sext_r = {{(ACC_W-PART_W){bus.in_result[RES_W-1]}},  bus.in_result[RES_W-1:PART_W]};
  assign sext_i = {{(ACC_W-PART_W){bus.in_result[PART_W-1]}}, bus.in_result[PART_W-1:0]};

  cplx_sat_add #(.W(ACC_W)) u_add_real (
    .a   (acc_r_q),
    .b   (sext_r),
    .sum (add_r),
    .ovf (add_ovf_r)
  );

  cplx_sat_add #(.W(ACC_W)) u_add_imag (
    .a   (acc_i_q),
    .b   (sext_i),
    .sum (add_i),
    .ovf (add_ovf_i)
  );

  // Ready enable: low while in reset, high from the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; clear beats any handshake.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ACC: if (accept)   state_d = bus.in_last ? HOLD : ACC;
        HOLD:      if (out_fire) state_d = IDLE;
        default:                 state_d = IDLE;
      endcase
    end
  end

  // Accumulators, beat count and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the accumulator state is plain flops, so it is reset asynchronously with everything else.
    if (!rst_n) begin
      acc_r_q <= '0;
      acc_i_q <= '0;
      cnt_q   <= '0;
      ovf_r_q <= 1'b0;
      ovf_i_q <= 1'b0;
    end else if (clear || out_fire) begin
      acc_r_q <= '0;
      acc_i_q <= '0;
      cnt_q   <= '0;
      ovf_r_q <= 1'b0;
      ovf_i_q <= 1'b0;
    end else if (accept) begin
      acc_r_q <= add_r;
      acc_i_q <= add_i;
      if (!(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
      ovf_r_q <= ovf_r_q | bus.in_ovf_real | add_ovf_r;
      ovf_i_q <= ovf_i_q | bus.in_ovf_imag | add_ovf_i;
    end
  end

  assign bus.out_sum      = {acc_r_q, acc_i_q};
  assign bus.out_count    = cnt_q;
  assign bus.out_ovf_real = ovf_r_q;
  assign bus.out_ovf_imag = ovf_i_q;

endmodule : cplx_accumulator

// File: tb/tb_cplx_accumulator.sv
// Scoreboard bench for cplx_accumulator (ACC_W=12, CNT_W=4).
// Expected sums come from an integer model; honours CPLX_ACC_SAT_EN.
module tb_cplx_accumulator;
  import cplx_pkg::*;

  localparam int ACC_W = 12;
  localparam int CNT_W = 4;
  localparam int MAXV  = 2**(ACC_W-1) - 1;
  localparam int MINV  = -(2**(ACC_W-1));
  localparam int CMAX  = 2**CNT_W - 1;

  typedef struct {
    logic [2*ACC_W-1:0] sum;
    logic [CNT_W-1:0]   cnt;
    logic               ovr;
    logic               ovi;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;

  cplx_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  cplx_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t sb[$];
  int   m_r, m_i, m_cnt;
  bit   m_ovr, m_ovi;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int mdl_add(int a, int b, output bit ovf);
    int s;
    s   = a + b;
    ovf = (s > MAXV) || (s < MINV);
`ifdef CPLX_ACC_SAT_EN
    if (s > MAXV)      s = MAXV;
    else if (s < MINV) s = MINV;
`else
    if (s > MAXV)      s = s - 2**ACC_W;
    else if (s < MINV) s = s + 2**ACC_W;
`endif
    return s;
  endfunction

  task automatic model_reset();
    m_r = 0; m_i = 0; m_cnt = 0; m_ovr = 0; m_ovi = 0;
  endtask

  task automatic model_accept(int r, int i, bit ovr, bit ovi, bit last);
    bit   o_r, o_i;
    exp_t e;
    m_r   = mdl_add(m_r, r, o_r);
    m_i   = mdl_add(m_i, i, o_i);
    m_ovr = m_ovr | ovr | o_r;
    m_ovi = m_ovi | ovi | o_i;
    if (m_cnt < CMAX) m_cnt++;
    if (last) begin
      e.sum = {m_r[ACC_W-1:0], m_i[ACC_W-1:0]};
      e.cnt = m_cnt[CNT_W-1:0];
      e.ovr = m_ovr;
      e.ovi = m_ovi;
      sb.push_back(e);
      model_reset();
    end
  endtask

  // Called at a negedge; presents one beat for the next rising edge.
  task automatic drive_beat(int r, int i, bit ovr, bit ovi, bit last);
    bus.in_valid    = 1'b1;
    bus.in_result   = {r[PART_W-1:0], i[PART_W-1:0]};
    bus.in_ovf_real = ovr;
    bus.in_ovf_imag = ovi;
    bus.in_last     = last;
    check("in_ready_before_beat", bus.in_ready, 1);
    if (bus.in_ready) model_accept(r, i, ovr, ovi, last);
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
    bus.in_ovf_real = 1'b0;
    bus.in_ovf_imag = 1'b0;
  endtask

  // Wait for a sum, compare against the scoreboard, stall, then consume it.
  task automatic collect(int hold_cycles);
    int   waited;
    exp_t e;
    waited = 0;
    while (!bus.out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("out_valid_seen", bus.out_valid, 1);
    check("sb_has_entry", (sb.size() != 0), 1);
    if (!bus.out_valid || sb.size() == 0) return;
    e = sb.pop_front();
    check("sum_real", bus.out_sum[2*ACC_W-1:ACC_W], e.sum[2*ACC_W-1:ACC_W]);
    check("sum_imag", bus.out_sum[ACC_W-1:0], e.sum[ACC_W-1:0]);
    check("count", bus.out_count, e.cnt);
    check("ovf_real", bus.out_ovf_real, e.ovr);
    check("ovf_imag", bus.out_ovf_imag, e.ovi);
    // Offer a beat while holding; it must be refused and change nothing.
    bus.in_valid  = 1'b1;
    bus.in_result = 22'h0ABCDE;
    bus.in_last   = 1'b1;
    for (int k = 0; k < hold_cycles; k++) begin
      @(negedge clk);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_sum", bus.out_sum, e.sum);
      check("hold_count", bus.out_count, e.cnt);
      check("hold_ovf", {bus.out_ovf_real, bus.out_ovf_imag}, {e.ovr, e.ovi});
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_fire_valid", bus.out_valid, 0);
    check("post_fire_sum", bus.out_sum, 0);
    check("post_fire_count", bus.out_count, 0);
    check("post_fire_ovf", {bus.out_ovf_real, bus.out_ovf_imag}, 0);
    check("post_fire_ready", bus.in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_result   = '0;
    bus.in_ovf_real = 1'b0;
    bus.in_ovf_imag = 1'b0;
    bus.in_last     = 1'b0;
    bus.out_ready   = 1'b0;
    model_reset();

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.out_sum, 0);
    check("rst_count", bus.out_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_in_ready_pre_edge", bus.in_ready, 0);
    @(negedge clk);
    check("rel_in_ready_first_edge", bus.in_ready, 1);

    // Three beats, sum available one cycle after the last.
    drive_beat(3, -2, 0, 0, 0);
    drive_beat(5, 4, 0, 0, 0);
    check("no_valid_mid_seq", bus.out_valid, 0);
    drive_beat(-1, 1, 0, 0, 1);
    check("valid_one_after_last", bus.out_valid, 1);
    collect(0);

    // Single beat with imaginary ALU overflow flag.
    drive_beat(10, -20, 0, 1, 1);
    collect(0);

    // Overflow of both halves: real upward, imaginary downward.
    drive_beat(1023, -1024, 0, 0, 0);
    drive_beat(1023, -1024, 0, 0, 0);
    drive_beat(1023, -1024, 0, 0, 1);
    collect(0);

    // Hold with consumer stalled for 5 cycles while a beat is offered.
    drive_beat(100, 200, 1, 0, 0);
    drive_beat(-300, 7, 0, 0, 1);
    collect(5);

    // Clear coincident with an accepted beat wins.
    drive_beat(5, 5, 0, 0, 0);
    bus.in_valid  = 1'b1;
    bus.in_result = {11'sd9, 11'sd9};
    clear = 1'b1;
    model_reset();
    @(negedge clk);
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_sum", bus.out_sum, 0);
    check("clear_count", bus.out_count, 0);
    check("clear_valid", bus.out_valid, 0);
    drive_beat(2, 3, 0, 0, 1);
    collect(0);

    // Count saturates at 2^CNT_W-1.
    for (int k = 0; k < 17; k++) drive_beat(1, 1, 0, 0, (k == 16));
    collect(0);

    // Reset mid-sequence discards the partial sum.
    drive_beat(50, 60, 1, 1, 0);
    drive_beat(70, 80, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_sum", bus.out_sum, 0);
    check("midrst_count", bus.out_count, 0);
    check("midrst_ovf", {bus.out_ovf_real, bus.out_ovf_imag}, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_no_valid", bus.out_valid, 0);
    end
    drive_beat(7, -7, 0, 0, 1);
    collect(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cplx_accumulator

// File: doc/cplx_accumulator.md
CPLX_ACCUMULATOR -- requirements
Module: cplx_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 16: width of each accumulator half (real, imag), two's complement, legal range 12..24.
REQ-002 SHALL have parameter CNT_W, default 8: width of the beat counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous reset, active-low.
REQ-005 SHALL have port clear, input, 1: synchronous clear of the accumulation.
REQ-006 SHALL have port in_valid, input, 1: input beat present.
REQ-007 SHALL have port in_ready, output, 1: block can accept a beat.
REQ-008 SHALL have port in_result, input, 22: ALU result; real = [21:11], imag = [10:0], each 11-bit two's complement.
REQ-009 SHALL have ports in_ovf_real and in_ovf_imag, input, 1 each: per-beat ALU overflow flags.
REQ-010 SHALL have port in_last, input, 1: marks the final beat of a sequence.
REQ-011 SHALL have port out_valid, output, 1: final sum available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the sum.
REQ-013 SHALL have port out_sum, output, 2*ACC_W: real = upper ACC_W bits, imag = lower ACC_W bits.
REQ-014 SHALL have port out_count, output, CNT_W: number of beats accumulated.
REQ-015 SHALL have ports out_ovf_real and out_ovf_imag, output, 1 each: sticky overflow per half.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, ACC, HOLD.
REQ-017 SHALL drive in_ready=1 in IDLE and ACC, and in_ready=0 in HOLD.
REQ-018 SHALL accept a beat when in_valid && in_ready; there is no combinational path from in_valid to in_ready.
REQ-019 On accept, SHALL sign-extend each 11-bit half to ACC_W and add it to the matching accumulator half in the same cycle.
REQ-020 On accept, SHALL increment count, saturating at 2^CNT_W-1.
REQ-021 Overflow flags SHALL be sticky: set by the input ovf flag of an accepted beat, or by signed overflow of the accumulator add for that half.
REQ-022 FSM: IDLE->ACC on accept with in_last=0; IDLE or ACC->HOLD on accept with in_last=1; otherwise no state change.
REQ-023 out_valid SHALL be 1 exactly in HOLD, from the cycle after the last beat is accepted; out_sum then includes that beat.
REQ-024 In HOLD, out_sum, out_count and the overflow flags SHALL stay stable until out_valid && out_ready.
REQ-025 HOLD->IDLE on out_valid && out_ready; in that same edge, accumulators, count and flags SHALL clear to 0.
REQ-026 clear=1 SHALL, in any state, zero accumulators, count and flags and go to IDLE; clear overrides a simultaneous accept or out handshake.
REQ-027 A beat with in_valid=1 in HOLD SHALL not be accepted and SHALL not alter state.
REQ-028 Without saturation, accumulator overflow SHALL wrap modulo 2^ACC_W.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, accumulators=0, count=0, flags=0, out_valid=0, in_ready=0.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge.
REQ-031 Reset asserted mid-sequence SHALL discard partial sums; no out_valid for that sequence.

Configuration
REQ-032 With macro CPLX_ACC_SAT_EN defined, each half SHALL clamp on overflow to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), still setting its sticky flag.
REQ-033 Without CPLX_ACC_SAT_EN, each half SHALL wrap per REQ-028; flags behave identically.

Structure
REQ-034 Package cplx_pkg SHALL hold: ALU part width (5), result part width (11), result bus width (22), and the FSM state type.
REQ-035 SHALL use one sub-module, cplx_sat_add: ACC_W signed add with an overflow output and saturation governed by CPLX_ACC_SAT_EN; instantiated twice (real, imag).

Verification
REQ-036 Scenario: three beats real/imag = (3,-2), (5,4), (-1,1), last on beat 3, out_ready=1 -> out_valid one cycle after beat 3, out_sum real=7, imag=3, count=3, flags=0.
REQ-037 Scenario: single beat with in_last=1 and in_ovf_imag=1 -> out_ovf_imag=1, out_ovf_real=0, count=1.
REQ-038 Scenario: ACC_W=12, repeatedly add real=+1023 until overflow -> sticky out_ovf_real=1; sum clamps at 2047 with CPLX_ACC_SAT_EN, wraps negative without it.
REQ-039 Scenario: hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 -> in_ready=0, outputs stable, no beat accepted; then out_ready=1 -> IDLE, accumulators 0.
REQ-040 Scenario: clear asserted in the same cycle as an accepted beat -> next cycle IDLE, sum=0, count=0.
REQ-041 Scenario: rst_n pulsed low mid-sequence -> immediate IDLE, all zero, no out_valid.
